scratchpad_sched: RTL and testbench

//  Read-side scheduler for one scratchpad bank. Accepts GEMM operand-fetch commands and store
//  (spill-to-DRAM) commands, expands each into per-row read requests, and round-robin arbitrates

---
 rtl/scratchpad_sched_pkg.sv | 27 ++
 rtl/scratchpad_sched_rr_arb2.sv | 23 ++
 rtl/scratchpad_sched.sv | 167 ++++++++++++++++
 tb/tb_scratchpad_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_sched_pkg.sv
// Shared types for the scratchpad read-side scheduler: rFIFO beat layout, matrix-type codes
// and sequencer state encodings.
package scratchpad_sched_pkg;

  localparam int MAT_S_W      = 3;
  localparam int ROWS_PER_MAT = 4;
  localparam int ROW_W        = $clog2(ROWS_PER_MAT);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_MAT - 1);

  typedef enum logic [1:0] {
    MAT_T_STORE = 2'd0,
    MAT_T_A     = 2'd1,
    MAT_T_B     = 2'd2,
    MAT_T_C     = 2'd3
  } mat_type_e;

  typedef struct packed {
    logic [1:0]         mat_t;
    logic [MAT_S_W-1:0] mat_s;
    logic [ROW_W-1:0]   row_s;
    logic [31:0]        addr;
  } rFIFO_t;

  typedef enum logic [1:0] {G_IDLE, G_A, G_B, G_C} gemm_seq_state_t;
  typedef enum logic {S_IDLE, S_ROWS} st_seq_state_t;

endpackage

// File: rtl/scratchpad_sched_rr_arb2.sv
// Two-way round-robin arbiter; the priority bit moves away from the winner only when a
// granted beat is actually pushed.
module scratchpad_sched_rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       push,
  output logic [1:0] grant
);

  logic prio;  // 0: req[0] wins a tie, 1: req[1] wins a tie

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) prio <= 1'b0;
    else if (push && (grant != 2'b00)) prio <= grant[0];
  end

endmodule

// File: rtl/scratchpad_sched.sv
// Read-side scheduler for one scratchpad bank: expands GEMM and store commands into row
// beats for the bank rFIFO. Optional stall counter: SCRATCHPAD_SCHED_STALL_CNT_EN.
module scratchpad_sched
  import scratchpad_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ROW_STRIDE      = 8,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               gemm_req,
  output logic               gemm_ready,
  input  logic [MAT_S_W-1:0] gemm_a,
  input  logic [MAT_S_W-1:0] gemm_b,
  input  logic [MAT_S_W-1:0] gemm_c,
  input  logic               st_req,
  output logic               st_ready,
  input  logic [MAT_S_W-1:0] st_mat,
  input  logic [31:0]        st_addr,
  input  logic               rFIFO_full,
  output logic               rFIFO_WEN,
  output rFIFO_t             rFIFO_wdata,
  input  logic               gemm_complete,
  output logic [OUT_W-1:0]   outstanding,
  output logic               busy,
  output gemm_seq_state_t    dbg_g_state,
  output st_seq_state_t      dbg_s_state
`ifdef SCRATCHPAD_SCHED_STALL_CNT_EN
  , output logic [31:0]      stall_cnt
`endif
);

  // Handshakes: a command transfers on the edge where *_req && *_ready; *_req must hold its
  // fields until then. A beat transfers on every edge where rFIFO_WEN is high.
  gemm_seq_state_t    g_state, g_next;
  st_seq_state_t      s_state, s_next;
  logic [ROW_W-1:0]   g_row, s_row;
  logic [MAT_S_W-1:0] g_a, g_b, g_c, st_mat_q;
  logic [31:0]        st_addr_q;
  logic [1:0]         grant;
  logic               g_pend, s_pend, push, g_push, s_push, g_last, s_last;
  logic               g_accept, s_accept, dec;
  rFIFO_t             wdata;

  assign g_pend   = (g_state != G_IDLE);
  assign s_pend   = (s_state != S_IDLE);
  assign push     = !rFIFO_full && (g_pend || s_pend);
  assign g_push   = push && grant[0];
  assign s_push   = push && grant[1];
  assign g_last   = g_push && (g_state == G_C) && (g_row == LAST_ROW);
  assign s_last   = s_push && (s_row == LAST_ROW);

  // Back-to-back GEMM accept is allowed only if the finishing GEMM still leaves room.
  assign gemm_ready = (g_state == G_IDLE) ? (outstanding < OUT_W'(MAX_OUTSTANDING))
                                          : (g_last && (outstanding < OUT_W'(MAX_OUTSTANDING - 1)));
  assign st_ready   = (s_state == S_IDLE) || s_last;
  assign g_accept   = gemm_req && gemm_ready;
  assign s_accept   = st_req && st_ready;

  scratchpad_sched_rr_arb2 u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .req   ({s_pend, g_pend}),
    .push  (push),
    .grant (grant)
  );

  always_comb begin
    g_next = g_state;
    if (g_accept) g_next = G_A;
    else if (g_push && (g_row == LAST_ROW)) begin
      case (g_state)
        G_A:     g_next = G_B;
        G_B:     g_next = G_C;
        default: g_next = G_IDLE;
      endcase
    end
  end

  always_comb begin
    s_next = s_state;
    if (s_accept) s_next = S_ROWS;
    else if (s_last) s_next = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      g_state <= G_IDLE;
      g_row   <= '0;
      g_a     <= '0;
      g_b     <= '0;
      g_c     <= '0;
    end else begin
      g_state <= g_next;
      if (g_accept) begin
        g_row <= '0;
        g_a   <= gemm_a;
        g_b   <= gemm_b;
        g_c   <= gemm_c;
      end else if (g_push) begin
        g_row <= g_row + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_state   <= S_IDLE;
      s_row     <= '0;
      st_mat_q  <= '0;
      st_addr_q <= '0;
    end else begin
      s_state <= s_next;
      if (s_accept) begin
        s_row     <= '0;
        st_mat_q  <= st_mat;
        st_addr_q <= st_addr;
      end else if (s_push) begin
        s_row <= s_row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    wdata = '0;
    if (grant[0]) begin
      wdata.row_s = g_row;
      case (g_state)
        G_A:     begin wdata.mat_t = MAT_T_A; wdata.mat_s = g_a; end
        G_B:     begin wdata.mat_t = MAT_T_B; wdata.mat_s = g_b; end
        G_C:     begin wdata.mat_t = MAT_T_C; wdata.mat_s = g_c; end
        default: ;
      endcase
    end else if (grant[1]) begin
      wdata.mat_t = MAT_T_STORE;
      wdata.mat_s = st_mat_q;
      wdata.row_s = s_row;
      wdata.addr  = st_addr_q + (32'(s_row) * 32'(ROW_STRIDE));
    end
  end

  assign rFIFO_WEN   = push;
  assign rFIFO_wdata = wdata;

  // A completion arriving with nothing outstanding is dropped rather than wrapping.
  assign dec = gemm_complete && (outstanding != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) outstanding <= '0;
    else if (g_last && !dec) outstanding <= outstanding + OUT_W'(1);
    else if (dec && !g_last) outstanding <= outstanding - OUT_W'(1);
  end

  assign busy        = g_pend || s_pend || (outstanding != '0);
  assign dbg_g_state = g_state;
  assign dbg_s_state = s_state;

`ifdef SCRATCHPAD_SCHED_STALL_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_cnt <= '0;
    else if ((g_pend || s_pend) && rFIFO_full && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_scratchpad_sched.sv
// Directed self-checking bench for scratchpad_sched: beats are captured at negedge and
// compared against an expected queue built from hand-specified commands.
module tb_scratchpad_sched;
  import scratchpad_sched_pkg::*;

  localparam int W = $bits(rFIFO_t);

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               gemm_req = 1'b0, st_req = 1'b0, rFIFO_full = 1'b0, gemm_complete = 1'b0;
  logic [MAT_S_W-1:0] gemm_a = '0, gemm_b = '0, gemm_c = '0, st_mat = '0;
  logic [31:0]        st_addr = '0;
  logic               gemm_ready, st_ready, rFIFO_WEN, busy;
  rFIFO_t             rFIFO_wdata;
  logic [1:0]         outstanding;
  gemm_seq_state_t    dbg_g;
  st_seq_state_t      dbg_s;

  scratchpad_sched dut (
    .CLK(CLK), .RST(RST),
    .gemm_req(gemm_req), .gemm_ready(gemm_ready),
    .gemm_a(gemm_a), .gemm_b(gemm_b), .gemm_c(gemm_c),
    .st_req(st_req), .st_ready(st_ready), .st_mat(st_mat), .st_addr(st_addr),
    .rFIFO_full(rFIFO_full), .rFIFO_WEN(rFIFO_WEN), .rFIFO_wdata(rFIFO_wdata),
    .gemm_complete(gemm_complete), .outstanding(outstanding), .busy(busy),
    .dbg_g_state(dbg_g), .dbg_s_state(dbg_s)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_t[$];
  int           checks = 0;
  int           errors = 0;

  always @(negedge CLK) begin
    if (!RST && rFIFO_WEN) begin
      got_q.push_back(rFIFO_wdata);
      got_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input int mt, input int ms, input int row,
                                        input logic [31:0] addr);
    rFIFO_t b;
    b.mat_t = 2'(mt);
    b.mat_s = MAT_S_W'(ms);
    b.row_s = ROW_W'(row);
    b.addr  = addr;
    return b;
  endfunction

  // drivers
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pushes(input string tag, input int n);
    int k = 0;
    while (got_q.size() < n && k < 500) begin
      step();
      k++;
    end
    check({tag, " push count"}, 64'(got_q.size()), 64'(n));
  endtask

  task automatic send_gemm(input int a, input int b, input int c, output int acc);
    int k = 0;
    gemm_a = MAT_S_W'(a); gemm_b = MAT_S_W'(b); gemm_c = MAT_S_W'(c);
    gemm_req = 1'b1;
    while (!gemm_ready && k < 500) begin step(); k++; end
    check("gemm accept", 64'(gemm_ready), 64'(1));
    step();
    gemm_req = 1'b0;
    acc = cyc;
  endtask

  task automatic send_store(input int m, input logic [31:0] addr, output int acc);
    int k = 0;
    st_mat = MAT_S_W'(m); st_addr = addr;
    st_req = 1'b1;
    while (!st_ready && k < 500) begin step(); k++; end
    check("store accept", 64'(st_ready), 64'(1));
    step();
    st_req = 1'b0;
    acc = cyc;
  endtask

  task automatic pulse_complete();
    gemm_complete = 1'b1;
    step();
    gemm_complete = 1'b0;
  endtask

  task automatic exp_gemm(input int a, input int b, input int c);
    for (int m = 1; m <= 3; m++)
      for (int r = 0; r < 4; r++)
        exp_q.push_back(beat(m, (m == 1) ? a : (m == 2) ? b : c, r, 32'h0));
  endtask

  task automatic drain_check(input string tag);
    check({tag, " beat total"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++)
      check($sformatf("%s beat%0d", tag, i), 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    int acc, acc2;
    rFIFO_t w;

    // reset state
    repeat (2) @(negedge CLK);
    check("rst WEN", 64'(rFIFO_WEN), 64'(0));
    check("rst gemm_ready", 64'(gemm_ready), 64'(1));
    check("rst st_ready", 64'(st_ready), 64'(1));
    check("rst outstanding", 64'(outstanding), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst wdata", 64'(rFIFO_wdata), 64'(0));
    check("rst g_state", 64'(dbg_g), 64'(G_IDLE));
    @(posedge CLK);
    #1 RST = 1'b0;

    // 1: single GEMM, latency and order
    send_gemm(1, 2, 3, acc);
    exp_gemm(1, 2, 3);
    wait_pushes("t1", 12);
    if (got_t.size() >= 12) begin
      check("t1 first beat cycle", 64'(got_t[0]), 64'(acc));
      check("t1 last beat cycle", 64'(got_t[11]), 64'(acc + 11));
    end
    drain_check("t1");
    step();
    check("t1 outstanding", 64'(outstanding), 64'(1));
    check("t1 busy", 64'(busy), 64'(1));
    pulse_complete();
    check("t1 retire", 64'(outstanding), 64'(0));
    check("t1 idle busy", 64'(busy), 64'(0));

    // 2: store, address wrap, back-to-back store
    send_store(2, 32'h1000, acc);
    exp_q.push_back(beat(0, 2, 0, 32'h1000));
    exp_q.push_back(beat(0, 2, 1, 32'h1008));
    exp_q.push_back(beat(0, 2, 2, 32'h1010));
    exp_q.push_back(beat(0, 2, 3, 32'h1018));
    wait_pushes("t2", 4);
    drain_check("t2");
    send_store(5, 32'hFFFF_FFF8, acc);
    send_store(6, 32'h20, acc2);
    exp_q.push_back(beat(0, 5, 0, 32'hFFFF_FFF8));
    exp_q.push_back(beat(0, 5, 1, 32'h0000_0000));
    exp_q.push_back(beat(0, 5, 2, 32'h0000_0008));
    exp_q.push_back(beat(0, 5, 3, 32'h0000_0010));
    exp_q.push_back(beat(0, 6, 0, 32'h20));
    exp_q.push_back(beat(0, 6, 1, 32'h28));
    exp_q.push_back(beat(0, 6, 2, 32'h30));
    exp_q.push_back(beat(0, 6, 3, 32'h38));
    wait_pushes("t2b", 8);
    if (got_t.size() >= 8) begin
      check("t2b accept on last beat", 64'(acc2), 64'(got_t[3] + 1));
      check("t2b no bubble", 64'(got_t[4]), 64'(got_t[3] + 1));
    end
    drain_check("t2b");

    // 3: GEMM and store together alternate, GEMM first
    gemm_a = 3'd4; gemm_b = 3'd5; gemm_c = 3'd6;
    st_mat = 3'd7; st_addr = 32'h200;
    gemm_req = 1'b1; st_req = 1'b1;
    step();
    gemm_req = 1'b0; st_req = 1'b0;
    acc = cyc;
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(beat(1, 4, r, 32'h0));
      exp_q.push_back(beat(0, 7, r, 32'h200 + 32'(r * 8)));
    end
    for (int r = 0; r < 4; r++) exp_q.push_back(beat(2, 5, r, 32'h0));
    for (int r = 0; r < 4; r++) exp_q.push_back(beat(3, 6, r, 32'h0));
    wait_pushes("t3", 16);
    if (got_t.size() >= 16) begin
      check("t3 first beat cycle", 64'(got_t[0]), 64'(acc));
      check("t3 last beat cycle", 64'(got_t[15]), 64'(acc + 15));
    end
    drain_check("t3");
    pulse_complete();
    check("t3 retire", 64'(outstanding), 64'(0));

    // 4: rFIFO_full stall mid-GEMM
    send_gemm(1, 3, 5, acc);
    exp_gemm(1, 3, 5);
    wait_pushes("t4 pre", 3);
    rFIFO_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      w = rFIFO_wdata;
      check($sformatf("t4 stall%0d WEN", i), 64'(rFIFO_WEN), 64'(0));
      check($sformatf("t4 stall%0d row", i), 64'(w.row_s), 64'(3));
      check($sformatf("t4 stall%0d mat_t", i), 64'(w.mat_t), 64'(1));
      check($sformatf("t4 stall%0d state", i), 64'(dbg_g), 64'(G_A));
      step();
    end
    rFIFO_full = 1'b0;
    check("t4 no push while full", 64'(got_q.size()), 64'(3));
    wait_pushes("t4", 12);
    drain_check("t4");
    check("t4 outstanding", 64'(outstanding), 64'(1));
    pulse_complete();
    check("t4 retire", 64'(outstanding), 64'(0));

    // 5: outstanding limit, simultaneous inc/dec, underflow guard
    send_gemm(1, 1, 1, acc);
    send_gemm(2, 2, 2, acc);
    exp_gemm(1, 1, 1);
    exp_gemm(2, 2, 2);
    wait_pushes("t5", 24);
    drain_check("t5");
    step();
    check("t5 outstanding max", 64'(outstanding), 64'(2));
    check("t5 gemm_ready at max", 64'(gemm_ready), 64'(0));
    check("t5 busy at max", 64'(busy), 64'(1));
    gemm_a = 3'd7; gemm_req = 1'b1;
    repeat (3) step();
    gemm_req = 1'b0;
    check("t5 blocked no push", 64'(got_q.size()), 64'(0));
    pulse_complete();
    check("t5 one retired", 64'(outstanding), 64'(1));
    send_gemm(3, 3, 3, acc);
    exp_gemm(3, 3, 3);
    wait_pushes("t5 third", 11);
    gemm_complete = 1'b1;
    step();
    gemm_complete = 1'b0;
    check("t5 inc+dec unchanged", 64'(outstanding), 64'(1));
    wait_pushes("t5 third", 12);
    drain_check("t5 third");
    pulse_complete();
    check("t5 drained", 64'(outstanding), 64'(0));
    pulse_complete();
    check("t5 no underflow", 64'(outstanding), 64'(0));
    check("t5 idle busy", 64'(busy), 64'(0));

    // 6: reset mid-GEMM
    send_gemm(2, 4, 6, acc);
    exp_gemm(2, 4, 6);
    wait_pushes("t6 pre", 12);
    drain_check("t6 pre");
    step();
    check("t6 outstanding before rst", 64'(outstanding), 64'(1));
    send_gemm(1, 2, 3, acc);
    wait_pushes("t6", 6);
    RST = 1'b1;
    @(negedge CLK);
    check("t6 WEN after rst", 64'(rFIFO_WEN), 64'(0));
    check("t6 gemm_ready after rst", 64'(gemm_ready), 64'(1));
    check("t6 st_ready after rst", 64'(st_ready), 64'(1));
    check("t6 outstanding after rst", 64'(outstanding), 64'(0));
    check("t6 busy after rst", 64'(busy), 64'(0));
    step();
    RST = 1'b0;
    repeat (3) step();
    check("t6 dropped beats", 64'(got_q.size()), 64'(6));
    check("t6 seq idle", 64'(dbg_g), 64'(G_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
